adc_slice_pfd_cal_seq: RTL and testbench

Per-slice calibration sequencer for the stochastic ADC slice; runs in the `clk_adder` domain beside the slice.
- On request, it reconfigures the PFD input muxes so that both PFD inputs see the `clk_adder`-derived test clock.
- It does this in two clock polarities, waits for the TDC/adder/retimer pipeline to settle, then accumulates signed ADC codes in each polarity.
- It reports the two averages and their mean, which is the PFD/TDC offset.
- Outside a calibration run it drives the mission configuration: V2T outputs routed to the PFD.

---
 rtl/adc_slice_pfd_cal_seq.sv | 182 ++++++++++++++++++
 tb/tb_adc_slice_pfd_cal_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_slice_pfd_cal_seq.sv
// PFD/TDC offset calibration sequencer for one stochastic ADC slice.
// Points both PFD inputs at the test clock in each polarity, lets the
// slice pipeline settle, then averages signed ADC codes per polarity.
// Reports both averages and their mean (the PFD/TDC offset).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | mission routing (sel=00), waiting for start
// S_CFG_A | test clock, polarity 0, settling; ADC input ignored
// S_ACC_A | test clock, polarity 0, accumulating 2^Nacc_log2 samples
// S_CFG_B | test clock, polarity 1, settling; ADC input ignored
// S_ACC_B | test clock, polarity 1, accumulating 2^Nacc_log2 samples
// S_FIN   | mission routing restored, done pulse, results valid
module adc_slice_pfd_cal_seq #(
  parameter int Nadc      = 8,
  parameter int Nacc_log2 = 4,
  parameter int Nsettle   = 8
) (
  input  logic                   clk_adder,
  input  logic                   rstb,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [Nadc-1:0]        adc_data_i,
  input  logic                   adc_sign_i,
  output logic [1:0]             sel_PFD_in_o,
  output logic                   sign_PFD_clk_in_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   res_valid_o,
  output logic signed [Nadc:0]   avg_a_o,
  output logic signed [Nadc:0]   avg_b_o,
  output logic signed [Nadc:0]   offset_o
);

  localparam int AW = Nadc + 1 + Nacc_log2;
  // One down-counter serves both settle and accumulate phases; 8 bits
  // covers Nsettle-1 <= 254 and 2^Nacc_log2-1 <= 255.
  localparam int CW = 8;
  localparam logic [CW-1:0] SETTLE_LD = CW'(Nsettle - 1);
  localparam logic [CW-1:0] ACC_LD    = CW'((1 << Nacc_log2) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_A, S_ACC_A, S_CFG_B, S_ACC_B, S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [Nadc:0]  avg_a_q, avg_a_d, avg_b_q, avg_b_d, offset_q, offset_d;
  logic                  res_valid_q, res_valid_d;
  logic [1:0]            sel_q, sel_d;
  logic                  sign_q, sign_d, busy_q, busy_d, done_q, done_d;

  logic signed [Nadc:0]   sample;
  logic signed [AW-1:0]   acc_sum;
  logic signed [Nadc:0]   avg_new;
  logic signed [Nadc+1:0] off_sum;
  logic signed [Nadc:0]   offset_new;

  // Sample conversion, running sum, floor-average and floor-mean of the two averages.
  always_comb begin
    sample     = adc_sign_i ? $signed({1'b0, adc_data_i}) : -$signed({1'b0, adc_data_i});
    acc_sum    = acc_q + {{Nacc_log2{sample[Nadc]}}, sample};
    avg_new    = (Nadc+1)'(acc_sum >>> Nacc_log2);
    off_sum    = {avg_a_q[Nadc], avg_a_q} + {avg_new[Nadc], avg_new};
    offset_new = (Nadc+1)'(off_sum >>> 1);
  end

  // Next-state, counter, accumulator and result updates; abort overrides all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    avg_a_d     = avg_a_q;
    avg_b_d     = avg_b_q;
    offset_d    = offset_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d     = S_CFG_A;
          cnt_d       = SETTLE_LD;
          acc_d       = '0;
          res_valid_d = 1'b0;
        end
      end
      S_CFG_A, S_CFG_B: begin
        if (cnt_q == '0) begin
          state_d = (state_q == S_CFG_A) ? S_ACC_A : S_ACC_B;
          cnt_d   = ACC_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACC_A: begin
        acc_d = acc_sum;
        if (cnt_q == '0) begin
          avg_a_d = avg_new;
          acc_d   = '0;
          cnt_d   = SETTLE_LD;
          state_d = S_CFG_B;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACC_B: begin
        acc_d = acc_sum;
        if (cnt_q == '0) begin
          avg_b_d     = avg_new;
          offset_d    = offset_new;
          res_valid_d = 1'b1;
          acc_d       = '0;
          state_d     = S_FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      avg_a_d     = avg_a_q;
      avg_b_d     = avg_b_q;
      offset_d    = offset_q;
      res_valid_d = res_valid_q;
    end
  end

  // Registered slice controls are decoded from the next state so they change with it.
  always_comb begin
    busy_d = state_d inside {S_CFG_A, S_ACC_A, S_CFG_B, S_ACC_B};
    sel_d  = busy_d ? 2'b11 : 2'b00;
    sign_d = state_d inside {S_CFG_B, S_ACC_B};
    done_d = (state_d == S_FIN);
  end

  // State register.
  always_ff @(posedge clk_adder or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_adder or negedge rstb) begin
    if (!rstb) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      avg_a_q     <= '0;
      avg_b_q     <= '0;
      offset_q    <= '0;
      res_valid_q <= 1'b0;
      sel_q       <= 2'b00;
      sign_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      avg_a_q     <= avg_a_d;
      avg_b_q     <= avg_b_d;
      offset_q    <= offset_d;
      res_valid_q <= res_valid_d;
      sel_q       <= sel_d;
      sign_q      <= sign_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel_PFD_in_o      = sel_q;
  assign sign_PFD_clk_in_o = sign_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign res_valid_o       = res_valid_q;
  assign avg_a_o           = avg_a_q;
  assign avg_b_o           = avg_b_q;
  assign offset_o          = offset_q;

endmodule

// File: tb/tb_adc_slice_pfd_cal_seq.sv
// Bench for adc_slice_pfd_cal_seq at default parameters (Nadc=8, 16 samples, settle 8).
module tb_adc_slice_pfd_cal_seq;

  localparam int NS = 8;
  localparam int NA = 16;
  localparam int DONE_CYC = 1 + 2 * (NS + NA);

  logic       clk_adder;
  logic       rstb;
  logic       start_i, abort_i;
  logic [7:0] adc_data_i;
  logic       adc_sign_i;
  logic [1:0] sel_PFD_in_o;
  logic       sign_PFD_clk_in_o, busy_o, done_o, res_valid_o;
  logic signed [8:0] avg_a_o, avg_b_o, offset_o;

  int checks   = 0;
  int failures = 0;

  // Model of the sticky result outputs.
  int m_avg_a = 0, m_avg_b = 0, m_off = 0, m_rv = 0;

  // Per-sample stimulus for the two polarities.
  int da[NA], sa[NA], db[NA], sb[NA];

  adc_slice_pfd_cal_seq dut (
    .clk_adder        (clk_adder),
    .rstb             (rstb),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .adc_data_i       (adc_data_i),
    .adc_sign_i       (adc_sign_i),
    .sel_PFD_in_o     (sel_PFD_in_o),
    .sign_PFD_clk_in_o(sign_PFD_clk_in_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .res_valid_o      (res_valid_o),
    .avg_a_o          (avg_a_o),
    .avg_b_o          (avg_b_o),
    .offset_o         (offset_o)
  );

  initial clk_adder = 1'b0;
  always #5 clk_adder = ~clk_adder;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input int cyc,
                     input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_adder);
    #1;
  endtask

  task automatic chk_results(input string tag, input int cyc);
    chk({tag, "_avg_a"}, cyc, avg_a_o, m_avg_a);
    chk({tag, "_avg_b"}, cyc, avg_b_o, m_avg_b);
    chk({tag, "_offset"}, cyc, offset_o, m_off);
    chk({tag, "_res_valid"}, cyc, res_valid_o, m_rv);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"}, 0, sel_PFD_in_o, 0);
    chk({tag, "_sign"}, 0, sign_PFD_clk_in_o, 0);
    chk({tag, "_busy"}, 0, busy_o, 0);
    chk({tag, "_done"}, 0, done_o, 0);
    chk({tag, "_res_valid"}, 0, res_valid_o, 0);
    chk({tag, "_avg_a"}, 0, avg_a_o, 0);
    chk({tag, "_avg_b"}, 0, avg_b_o, 0);
    chk({tag, "_offset"}, 0, offset_o, 0);
  endtask

  // One calibration run starting at edge k=0; abort_k<0 means no abort.
  // Observation after edge k is cycle k+1 relative to the start edge.
  task automatic run_cal(input string tag, input int abort_k);
    int sum_a, sum_b, e_a, e_b, e_off, kmax, n;
    bit aborted, e_busy, e_sign, e_done;
    sum_a = 0;
    sum_b = 0;
    for (int i = 0; i < NA; i++) begin
      sum_a += sa[i] ? da[i] : -da[i];
      sum_b += sb[i] ? db[i] : -db[i];
    end
    e_a   = fdiv(sum_a, NA);
    e_b   = fdiv(sum_b, NA);
    e_off = fdiv(e_a + e_b, 2);
    kmax  = (abort_k >= 0) ? abort_k + 4 : DONE_CYC;
    for (int k = 0; k <= kmax; k++) begin
      if (k == 0)                       start_i = 1'b1;
      else if (abort_k < 0 && k < 48)   start_i = 1'($urandom_range(0, 1));
      else                              start_i = 1'b0;
      abort_i = (k == abort_k);
      if (k >= 1 + NS && k < 1 + NS + NA) begin
        adc_data_i = 8'(da[k - 1 - NS]);
        adc_sign_i = 1'(sa[k - 1 - NS]);
      end else if (k >= 1 + 2 * NS + NA && k < DONE_CYC) begin
        adc_data_i = 8'(db[k - 1 - 2 * NS - NA]);
        adc_sign_i = 1'(sb[k - 1 - 2 * NS - NA]);
      end else begin
        adc_data_i = 8'($urandom_range(0, 255));
        adc_sign_i = 1'($urandom_range(0, 1));
      end
      tick();
      n = k + 1;
      aborted = (abort_k >= 0) && (k >= abort_k);
      if (k == 0) m_rv = 0;
      if (!aborted && n == 1 + NS + NA) m_avg_a = e_a;
      if (!aborted && n == DONE_CYC) begin
        m_avg_b = e_b;
        m_off   = e_off;
        m_rv    = 1;
      end
      e_busy = !aborted && n >= 1 && n < DONE_CYC;
      e_sign = !aborted && n >= 1 + NS + NA && n < DONE_CYC;
      e_done = !aborted && n == DONE_CYC;
      chk({tag, "_busy"}, n, busy_o, e_busy);
      chk({tag, "_sel"}, n, sel_PFD_in_o, e_busy ? 3 : 0);
      chk({tag, "_sign"}, n, sign_PFD_clk_in_o, e_sign);
      chk({tag, "_done"}, n, done_o, e_done);
      chk_results(tag, n);
    end
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  initial begin
    rstb = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    adc_data_i = '0;
    adc_sign_i = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      start_i    = 1'($urandom_range(0, 1));
      abort_i    = 1'($urandom_range(0, 1));
      adc_data_i = 8'($urandom_range(0, 255));
      adc_sign_i = 1'($urandom_range(0, 1));
      tick();
    end
    chk_reset_vals("reset");
    start_i = 1'b0;
    abort_i = 1'b0;
    rstb = 1'b1;
    tick();
    tick();

    // Constant codes.
    for (int i = 0; i < NA; i++) begin
      da[i] = 5; sa[i] = 1; db[i] = 3; sb[i] = 0;
    end
    run_cal("const", -1);
    chk("const_avg_a_abs", 0, avg_a_o, 5);
    chk("const_avg_b_abs", 0, avg_b_o, -3);
    chk("const_offset_abs", 0, offset_o, 1);

    // Floor rounding: +1/-2 alternating, then zeros.
    for (int i = 0; i < NA; i++) begin
      da[i] = (i % 2 == 0) ? 1 : 2;
      sa[i] = (i % 2 == 0) ? 1 : 0;
      db[i] = 0;
      sb[i] = int'($urandom_range(0, 1));
    end
    run_cal("floor", -1);
    chk("floor_avg_a_abs", 0, avg_a_o, -1);
    chk("floor_offset_abs", 0, offset_o, -1);

    // Full scale in both polarities.
    for (int i = 0; i < NA; i++) begin
      da[i] = 255; sa[i] = 1; db[i] = 255; sb[i] = 0;
    end
    run_cal("full", -1);
    chk("full_avg_a_abs", 0, avg_a_o, 255);
    chk("full_avg_b_abs", 0, avg_b_o, -255);
    chk("full_offset_abs", 0, offset_o, 0);

    // Random codes.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NA; i++) begin
        da[i] = int'($urandom_range(0, 255)); sa[i] = int'($urandom_range(0, 1));
        db[i] = int'($urandom_range(0, 255)); sb[i] = int'($urandom_range(0, 1));
      end
      run_cal("rand", -1);
    end

    // Abort in CFG_B, then a normal run.
    for (int i = 0; i < NA; i++) begin
      da[i] = int'($urandom_range(0, 255)); sa[i] = int'($urandom_range(0, 1));
      db[i] = int'($urandom_range(0, 255)); sb[i] = int'($urandom_range(0, 1));
    end
    run_cal("abort_cfgb", 1 + NS + NA + 3);
    for (int i = 0; i < NA; i++) begin
      da[i] = int'($urandom_range(0, 255)); sa[i] = int'($urandom_range(0, 1));
      db[i] = int'($urandom_range(0, 255)); sb[i] = int'($urandom_range(0, 1));
    end
    run_cal("after_abort", -1);

    // start and abort together in IDLE: no run.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("collide_busy", i, busy_o, 0);
      chk("collide_sel", i, sel_PFD_in_o, 0);
      tick();
    end
    chk_results("collide", 0);

    // Reset pulse during ACC_A.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < NS + 4; i++) tick();
    chk("pre_rst_busy", 0, busy_o, 1);
    #2;
    rstb = 1'b0;
    #1;
    m_avg_a = 0; m_avg_b = 0; m_off = 0; m_rv = 0;
    chk_reset_vals("midrun_rst");
    tick();
    rstb = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    // Normal run after reset.
    for (int i = 0; i < NA; i++) begin
      da[i] = int'($urandom_range(0, 255)); sa[i] = int'($urandom_range(0, 1));
      db[i] = int'($urandom_range(0, 255)); sb[i] = int'($urandom_range(0, 1));
    end
    run_cal("after_rst", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
